// File: rtl/alu_pkg.sv
// Shared types and opcode helpers for the ALU sequencer.
package alu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXEC    = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DWELL   = 2'd3
  } seq_state_t;

  localparam logic [2:0] OP_000 = 3'b000;
  localparam logic [2:0] OP_001 = 3'b001;
  localparam logic [2:0] OP_010 = 3'b010;
  localparam logic [2:0] OP_011 = 3'b011;
  localparam logic [2:0] OP_100 = 3'b100;
  localparam logic [2:0] OP_101 = 3'b101;
  localparam logic [2:0] OP_110 = 3'b110;
  localparam logic [2:0] OP_111 = 3'b111;

  function automatic logic is_valid_op(input logic [2:0] op);
    return (op != OP_010) && (op != OP_011);
  endfunction

  // Auto-mode walk over the valid opcodes; anything else restarts the walk.
  function automatic logic [2:0] next_op(input logic [2:0] op);
    logic [2:0] nxt;
    case (op)
      OP_000:  nxt = OP_001;
      OP_001:  nxt = OP_100;
      OP_100:  nxt = OP_101;
      OP_101:  nxt = OP_110;
      OP_110:  nxt = OP_111;
      default: nxt = OP_000;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/go_sync_edge.sv
// Two-flop synchronizer plus rising-edge detector for the asynchronous go button.
module go_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic rise_c
);

  logic       s1_q;
  logic       s2_q;
  logic       prev_q;
  logic       armed_q;
  logic [1:0] fill_q;

  // fill_q marks when s2_q carries a real sample; arming waits for a low
  // level so a button held through reset release cannot fake an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      prev_q  <= 1'b0;
      armed_q <= 1'b0;
      fill_q  <= 2'b00;
    end else begin
      s1_q   <= btn_i;
      s2_q   <= s1_q;
      prev_q <= s2_q;
      fill_q <= {fill_q[0], 1'b1};
      if (fill_q[1] && !s2_q) begin
        armed_q <= 1'b1;
      end
    end
  end

  assign rise_c = armed_q & s2_q & ~prev_q;

endmodule

// File: rtl/alu_sequencer.sv
// Button-driven sequencer feeding the signed ALU and latching results for the
// seven-segment decoder, with an auto mode that walks all valid opcodes.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned OPW          = 5,
  parameter int unsigned DWELL_CYCLES = 50_000_000
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [OPW-1:0] a_sw,
  input  logic [OPW-1:0] b_sw,
  input  logic [2:0]     instr_sw,
  input  logic           auto_sw,
  input  logic           go_btn,
  output logic [OPW-1:0] alu_a,
  output logic [OPW-1:0] alu_b,
  output logic [2:0]     alu_instr,
  input  logic [5:0]     alu_c,
  output logic [5:0]     disp_c,
  output logic [2:0]     disp_instr,
  output logic           busy,
  output logic           done
);

  localparam int unsigned CNT_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL_CYCLES - 1);

  seq_state_t     state_q, state_d;
  logic           auto_q, auto_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [OPW-1:0] a_q, a_d;
  logic [OPW-1:0] b_q, b_d;
  logic [2:0]     instr_q, instr_d;
  logic [5:0]     disp_c_q, disp_c_d;
  logic [2:0]     disp_instr_q, disp_instr_d;
  logic           done_q, done_d;
  logic           busy_q, busy_d;
  logic           go_rise;
  logic           abort;

  go_sync_edge u_go_sync_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_i  (go_btn),
    .rise_c (go_rise)
  );

  // A press during an auto run cancels it; manual runs ignore presses.
  assign abort = go_rise & auto_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      auto_q       <= 1'b0;
      cnt_q        <= '0;
      a_q          <= '0;
      b_q          <= '0;
      instr_q      <= OP_000;
      disp_c_q     <= '0;
      disp_instr_q <= OP_000;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      auto_q       <= auto_d;
      cnt_q        <= cnt_d;
      a_q          <= a_d;
      b_q          <= b_d;
      instr_q      <= instr_d;
      disp_c_q     <= disp_c_d;
      disp_instr_q <= disp_instr_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    auto_d       = auto_q;
    cnt_d        = cnt_q;
    a_d          = a_q;
    b_d          = b_q;
    instr_d      = instr_q;
    disp_c_d     = disp_c_q;
    disp_instr_d = disp_instr_q;
    done_d       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (go_rise) begin
          a_d     = a_sw;
          b_d     = b_sw;
          auto_d  = auto_sw;
          instr_d = auto_sw ? OP_000 : instr_sw;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        state_d = abort ? ST_IDLE : ST_CAPTURE;
      end
      ST_CAPTURE: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          disp_c_d     = alu_c;
          disp_instr_d = instr_q;
          done_d       = 1'b1;
          cnt_d        = '0;
          state_d      = auto_q ? ST_DWELL : ST_IDLE;
        end
      end
      ST_DWELL: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          if (instr_q == OP_111) begin
            state_d = ST_IDLE;
          end else begin
            instr_d = next_op(instr_q);
            state_d = ST_EXEC;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_instr  = instr_q;
  assign disp_c     = disp_c_q;
  assign disp_instr = disp_instr_q;
  assign done       = done_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer with a behavioural 6-bit signed ALU.
module tb_alu_sequencer;

  localparam int unsigned OPW   = 5;
  localparam int unsigned DWELL = 4;

  typedef struct packed {
    logic [5:0] c;
    logic [2:0] op;
  } exp_t;

  logic           clk;
  logic           rst_n;
  logic [OPW-1:0] a_sw;
  logic [OPW-1:0] b_sw;
  logic [2:0]     instr_sw;
  logic           auto_sw;
  logic           go_btn;
  logic [OPW-1:0] alu_a;
  logic [OPW-1:0] alu_b;
  logic [2:0]     alu_instr;
  logic [5:0]     alu_c;
  logic [5:0]     disp_c;
  logic [2:0]     disp_instr;
  logic           busy;
  logic           done;

  int   n_checks;
  int   n_fail;
  int   done_cnt;
  int   cyc;
  exp_t sb_q[$];

  alu_sequencer #(
    .OPW          (OPW),
    .DWELL_CYCLES (DWELL)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .a_sw       (a_sw),
    .b_sw       (b_sw),
    .instr_sw   (instr_sw),
    .auto_sw    (auto_sw),
    .go_btn     (go_btn),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_instr  (alu_instr),
    .alu_c      (alu_c),
    .disp_c     (disp_c),
    .disp_instr (disp_instr),
    .busy       (busy),
    .done       (done)
  );

  function automatic logic [5:0] alu_f(input logic [4:0] a, input logic [4:0] b,
                                       input logic [2:0] op);
    logic [5:0] sa;
    logic [5:0] sb;
    logic [5:0] r;
    sa = {a[4], a};
    sb = {b[4], b};
    case (op)
      3'b000:  r = sa + sb;
      3'b001:  r = sa - sb;
      3'b100:  r = sa & sb;
      3'b101:  r = sa | sb;
      3'b110:  r = sa ^ sb;
      3'b111:  r = ~sa;
      default: r = 6'b101010;
    endcase
    return r;
  endfunction

  assign alu_c = alu_f(alu_a, alu_b, alu_instr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest expected result.
  always @(negedge clk) begin
    if (rst_n && done) begin
      exp_t e;
      done_cnt = done_cnt + 1;
      if (sb_q.size() == 0) begin
        check_eq("spurious_done", 32'(done), 32'd0);
      end else begin
        e = sb_q.pop_front();
        check_eq("sb_disp_c", 32'(disp_c), 32'(e.c));
        check_eq("sb_disp_instr", 32'(disp_instr), 32'(e.op));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string tag, input int maxc);
    int k;
    k = 0;
    do begin
      tick(1);
      k++;
    end while (!done && k < maxc);
    if (!done) check_eq(tag, 32'(done), 32'd1);
  endtask

  task automatic set_sw(input logic [4:0] a, input logic [4:0] b, input logic [2:0] op,
                        input logic au);
    a_sw     = a;
    b_sw     = b;
    instr_sw = op;
    auto_sw  = au;
  endtask

  task automatic manual_run(input string tag, input logic [4:0] a, input logic [4:0] b,
                            input logic [2:0] op);
    set_sw(a, b, op, 1'b0);
    sb_q.push_back('{c: alu_f(a, b, op), op: op});
    go_btn = 1'b1;
    tick(2);
    go_btn = 1'b0;
    wait_done(tag, 10);
    tick(2);
  endtask

  logic [2:0] ops [6];
  int         t [6];
  int         d0;

  initial begin
    ops = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111};
    n_checks = 0;
    n_fail   = 0;
    done_cnt = 0;
    cyc      = 0;
    rst_n    = 1'b0;
    go_btn   = 1'b0;
    set_sw(5'd0, 5'd0, 3'b000, 1'b0);

    #3;
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_disp", 32'({disp_c, disp_instr}), 32'd0);
    check_eq("rst_alu", 32'({alu_a, alu_b, alu_instr}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(4);

    // Manual launch: edge-by-edge latency and busy window.
    set_sw(5'd5, 5'd3, 3'b000, 1'b0);
    sb_q.push_back('{c: 6'd8, op: 3'b000});
    go_btn = 1'b1;
    tick(1);
    tick(1);
    check_eq("ml_busy_e1", 32'(busy), 32'd0);
    tick(1);
    go_btn = 1'b0;
    check_eq("ml_busy_e2", 32'(busy), 32'd1);
    check_eq("ml_ops_e2", 32'({alu_a, alu_b, alu_instr}), 32'({5'd5, 5'd3, 3'b000}));
    tick(1);
    check_eq("ml_busy_e3", 32'(busy), 32'd1);
    check_eq("ml_done_e3", 32'(done), 32'd0);
    tick(1);
    check_eq("ml_done_e4", 32'(done), 32'd1);
    check_eq("ml_disp_c", 32'(disp_c), 32'd8);
    check_eq("ml_busy_e4", 32'(busy), 32'd0);
    tick(1);
    check_eq("ml_done_e5", 32'(done), 32'd0);
    tick(2);

    // Invalid opcode passes through; negative result shown raw.
    manual_run("inv_timeout", 5'd3, 5'd1, 3'b010);
    check_eq("inv_disp_instr", 32'(disp_instr), 32'd2);
    manual_run("neg_timeout", 5'd2, 5'd5, 3'b001);
    check_eq("neg_disp_c", 32'(disp_c), 32'(6'b111101));

    // Auto run over all six valid opcodes.
    set_sw(5'd7, 5'd2, 3'b010, 1'b1);
    for (int i = 0; i < 6; i++) sb_q.push_back('{c: alu_f(5'd7, 5'd2, ops[i]), op: ops[i]});
    go_btn = 1'b1;
    tick(2);
    go_btn = 1'b0;
    for (int i = 0; i < 6; i++) begin
      wait_done("auto_timeout", 40);
      t[i] = cyc;
      check_eq("auto_instr", 32'(alu_instr), 32'(ops[i]));
    end
    for (int i = 1; i < 6; i++) check_eq("auto_spacing", 32'(t[i] - t[i-1]), 32'(DWELL + 2));
    tick(DWELL - 1);
    check_eq("auto_busy_hold", 32'(busy), 32'd1);
    tick(1);
    check_eq("auto_busy_fall", 32'(busy), 32'd0);
    tick(3);

    // Abort after the second done.
    set_sw(5'd1, 5'd4, 3'b000, 1'b1);
    for (int i = 0; i < 2; i++) sb_q.push_back('{c: alu_f(5'd1, 5'd4, ops[i]), op: ops[i]});
    go_btn = 1'b1;
    tick(2);
    go_btn = 1'b0;
    wait_done("abort_timeout", 40);
    wait_done("abort_timeout", 40);
    go_btn = 1'b1;
    tick(2);
    check_eq("abort_busy_rise", 32'(busy), 32'd1);
    tick(1);
    check_eq("abort_busy_idle", 32'(busy), 32'd0);
    check_eq("abort_disp_instr", 32'(disp_instr), 32'd1);
    go_btn = 1'b0;
    d0 = done_cnt;
    tick(20);
    check_eq("abort_no_done", 32'(done_cnt - d0), 32'd0);

    // Second press while the manual run is in flight is ignored.
    set_sw(5'd9, 5'd4, 3'b000, 1'b0);
    sb_q.push_back('{c: alu_f(5'd9, 5'd4, 3'b000), op: 3'b000});
    d0 = done_cnt;
    go_btn = 1'b1;
    tick(1);
    go_btn = 1'b0;
    tick(1);
    go_btn = 1'b1;
    tick(1);
    set_sw(5'd1, 5'd1, 3'b111, 1'b1);
    check_eq("ign_ops", 32'({alu_a, alu_b}), 32'({5'd9, 5'd4}));
    tick(12);
    check_eq("ign_one_done", 32'(done_cnt - d0), 32'd1);
    check_eq("ign_busy", 32'(busy), 32'd0);
    go_btn = 1'b0;
    tick(4);

    // Asynchronous reset during DWELL with the button held through release.
    set_sw(5'd3, 5'd6, 3'b000, 1'b1);
    sb_q.push_back('{c: alu_f(5'd3, 5'd6, 3'b000), op: 3'b000});
    go_btn = 1'b1;
    tick(2);
    go_btn = 1'b0;
    wait_done("rst_timeout", 20);
    tick(2);
    go_btn = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_alu", 32'({alu_a, alu_b, alu_instr}), 32'd0);
    check_eq("mid_rst_disp", 32'({disp_c, disp_instr}), 32'd0);
    check_eq("mid_rst_busy", 32'(busy), 32'd0);
    check_eq("mid_rst_done", 32'(done), 32'd0);
    tick(2);
    @(negedge clk);
    rst_n = 1'b1;
    d0 = done_cnt;
    tick(10);
    check_eq("held_no_run", 32'(busy), 32'd0);
    check_eq("held_no_latch", 32'(alu_a), 32'd0);
    check_eq("held_no_done", 32'(done_cnt - d0), 32'd0);
    go_btn = 1'b0;
    tick(4);

    manual_run("recover_timeout", 5'd4, 5'd4, 3'b101);
    check_eq("recover_disp_c", 32'(disp_c), 32'd4);

    check_eq("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
